// File: rtl/serial_subtractor.sv
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial two's-complement subtractor (diff = a - b), LSB
//               first, one full-adder slice plus a carry flop, with
//               valid/ready handshakes on operands and result.
//               Optional macro SERIAL_SUB_ABS_EN adds a bit-serial magnitude
//               (ABS) pass producing `mag`; without it `mag` is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             neg,
  output logic [WIDTH-1:0] mag
);

  localparam int         CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
`ifdef SERIAL_SUB_ABS_EN
    S_ABS  = 2'd3,
`endif
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_borrow;
  logic             r_ovf;
  logic             r_neg;

  logic             w_fa_x;
  logic             w_fa_y;
  logic             w_sum;
  logic             w_cout;
  logic             w_last;
  logic             w_in_ready;
  logic             w_out_valid;

`ifdef SERIAL_SUB_ABS_EN
  logic [WIDTH-1:0] r_mag;
`endif

  // The single adder slice: RUN feeds a + ~b; ABS feeds ~diff + 0 (carry preset
  // to 1 supplies the +1 of both the subtraction and the negation).
  always_comb begin
    w_fa_x = r_a[0];
    w_fa_y = ~r_b[0];
`ifdef SERIAL_SUB_ABS_EN
    if (r_state == S_ABS) begin
      w_fa_x = ~r_diff[0];
      w_fa_y = 1'b0;
    end
`endif
  end

  assign w_sum  = w_fa_x ^ w_fa_y ^ r_carry;
  assign w_cout = (w_fa_x & w_fa_y) | (w_fa_x & r_carry) | (w_fa_y & r_carry);
  assign w_last = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
`ifdef SERIAL_SUB_ABS_EN
          w_next = w_sum ? S_ABS : S_DONE;
`else
          w_next = S_DONE;
`endif
        end
      end
`ifdef SERIAL_SUB_ABS_EN
      S_ABS: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
`endif
      S_DONE: begin
        w_out_valid = 1'b1;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_neg    <= 1'b0;
`ifdef SERIAL_SUB_ABS_EN
      r_mag    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= 1'b1;
            r_cnt   <= CNT_LOAD;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_diff  <= {w_sum, r_diff[WIDTH-1:1]};
          r_carry <= w_cout;
          r_cnt   <= r_cnt - CNT_W'(1);
          if (w_last) begin
            // r_carry here is the carry into the MSB; w_cout is the carry out.
            r_borrow <= ~w_cout;
            r_ovf    <= r_carry ^ w_cout;
            r_neg    <= w_sum;
`ifdef SERIAL_SUB_ABS_EN
            r_carry  <= 1'b1;
            r_cnt    <= CNT_LOAD;
            if (!w_sum) begin
              r_mag <= {w_sum, r_diff[WIDTH-1:1]};
            end
`endif
          end
        end
`ifdef SERIAL_SUB_ABS_EN
        S_ABS: begin
          // Rotate so diff is intact again after WIDTH cycles.
          r_diff  <= {r_diff[0], r_diff[WIDTH-1:1]};
          r_mag   <= {w_sum, r_mag[WIDTH-1:1]};
          r_carry <= w_cout;
          r_cnt   <= r_cnt - CNT_W'(1);
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign diff      = r_diff;
  assign borrow    = r_borrow;
  assign ovf       = r_ovf;
  assign neg       = r_neg;

`ifdef SERIAL_SUB_ABS_EN
  assign mag = r_mag;
`else
  assign mag = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Directed self-checking bench for serial_subtractor (WIDTH=4),
//               aware of the optional SERIAL_SUB_ABS_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  localparam int W = 4;
`ifdef SERIAL_SUB_ABS_EN
  localparam bit ABS = 1'b1;
`else
  localparam bit ABS = 1'b0;
`endif

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;
  logic         neg;
  logic [W-1:0] mag;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf),
    .neg       (neg),
    .mag       (mag)
  );

  always #5 clk = ~clk;

  // Present operands for one capture edge, then count edges until out_valid.
  task automatic start_and_wait(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                output int lat);
    @(negedge clk);
    a        = ta;
    b        = tb_v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    lat      = 0;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic accept_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (diff !== 4'b0000) begin errors++; $display("FAIL reset_diff got=%b exp=0000", diff); end
    checks++; if (mag !== 4'b0000) begin errors++; $display("FAIL reset_mag got=%b exp=0000", mag); end
    checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow got=%b exp=0", borrow); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (neg !== 1'b0) begin errors++; $display("FAIL reset_neg got=%b exp=0", neg); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [6] = '{4'd3,    4'b0111, 4'b1000, 4'd0,    4'd6,    4'd5};
    logic [W-1:0] vb [6] = '{4'd5,    4'b1000, 4'b0001, 4'b1000, 4'd2,    4'd5};
    logic [W-1:0] ed [6] = '{4'b1110, 4'b1111, 4'b0111, 4'b1000, 4'b0100, 4'b0000};
    logic         eb [6] = '{1'b1,    1'b1,    1'b0,    1'b1,    1'b0,    1'b0};
    logic         eo [6] = '{1'b0,    1'b1,    1'b1,    1'b1,    1'b0,    1'b0};
    logic         en [6] = '{1'b1,    1'b1,    1'b0,    1'b1,    1'b0,    1'b0};
    logic [W-1:0] em [6] = '{4'b0010, 4'b0001, 4'b0111, 4'b1000, 4'b0100, 4'b0000};
    int lat;
    int exp_lat;
    logic [W-1:0] exp_mag;
    for (int i = 0; i < 6; i++) begin
      start_and_wait(va[i], vb[i], lat);
      exp_lat = (ABS && en[i]) ? 2 * W : W;
      exp_mag = ABS ? em[i] : 4'b0000;
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL v%0d_latency got=%0d exp=%0d", i, lat, exp_lat); end
      checks++; if (diff !== ed[i]) begin errors++; $display("FAIL v%0d_diff got=%b exp=%b", i, diff, ed[i]); end
      checks++; if (borrow !== eb[i]) begin errors++; $display("FAIL v%0d_borrow got=%b exp=%b", i, borrow, eb[i]); end
      checks++; if (ovf !== eo[i]) begin errors++; $display("FAIL v%0d_ovf got=%b exp=%b", i, ovf, eo[i]); end
      checks++; if (neg !== en[i]) begin errors++; $display("FAIL v%0d_neg got=%b exp=%b", i, neg, en[i]); end
      checks++; if (mag !== exp_mag) begin errors++; $display("FAIL v%0d_mag got=%b exp=%b", i, mag, exp_mag); end
      accept_result();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    start_and_wait(4'd3, 4'd5, lat);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      a        = W'(c + 7);
      b        = W'(c);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp%0d_out_valid got=%b exp=1", c, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp%0d_in_ready got=%b exp=0", c, in_ready); end
      checks++; if ({diff, borrow, ovf, neg} !== {4'b1110, 1'b1, 1'b0, 1'b1}) begin
        errors++; $display("FAIL bp%0d_hold got=%b exp=1110101", c, {diff, borrow, ovf, neg});
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    // Leave non-zero flags behind so the abort has something to clear.
    start_and_wait(4'd3, 4'd5, lat);
    accept_result();
    @(negedge clk);
    a        = 4'd3;
    b        = 4'd5;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got=%b exp=0", out_valid); end
    checks++; if ({diff, mag} !== 8'h00) begin errors++; $display("FAIL abort_diff_mag got=%h exp=00", {diff, mag}); end
    checks++; if ({borrow, ovf, neg} !== 3'b000) begin errors++; $display("FAIL abort_flags got=%b exp=000", {borrow, ovf, neg}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_release_in_ready got=%b exp=1", in_ready); end
    start_and_wait(4'd6, 4'd2, lat);
    checks++; if (lat !== W) begin errors++; $display("FAIL post_abort_latency got=%0d exp=%0d", lat, W); end
    checks++; if (diff !== 4'b0100) begin errors++; $display("FAIL post_abort_diff got=%b exp=0100", diff); end
    checks++; if ({borrow, ovf, neg} !== 3'b000) begin errors++; $display("FAIL post_abort_flags got=%b exp=000", {borrow, ovf, neg}); end
    accept_result();
  endtask

  task automatic test_back_to_back();
    int gap;
    int wait_cyc;
    @(negedge clk);
    a         = 4'd6;
    b         = 4'd2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    wait_cyc  = 0;
    while (out_valid !== 1'b1 && wait_cyc < 64) begin
      @(negedge clk);
      wait_cyc++;
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_timeout got=%b exp=1", out_valid); end
    gap = 0;
    @(negedge clk);
    gap++;
    while (out_valid !== 1'b1 && gap < 64) begin
      @(negedge clk);
      gap++;
    end
    in_valid = 1'b0;
    checks++; if (gap !== W + 2) begin errors++; $display("FAIL b2b_interval got=%0d exp=%0d", gap, W + 2); end
    checks++; if (diff !== 4'b0100) begin errors++; $display("FAIL b2b_diff got=%b exp=0100", diff); end
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle got=%b exp=1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

- Bit-serial two's-complement subtractor: computes `diff = a - b` one bit per clock, LSB first, with a single full-adder slice and a carry flop.
- Operands enter on a valid/ready handshake; the result leaves on a second valid/ready handshake with borrow, signed-overflow and sign flags.
- It is the inverse arithmetic companion to the ripple adder. It is the area-minimal path for subtraction and sign handling in the datapath.

## Interface

- `WIDTH`, default 4: operand and result width in bits; legal range is 2 to 16.

- `clk` — input, 1 bit: rising-edge clock.
- `rst_n` — input, 1 bit: asynchronous active-low reset.
- `in_valid` — input, 1 bit: the operands on `a` and `b` are valid.
- `in_ready` — output, 1 bit: the block can accept operands; high only in IDLE.
- `a` — input, `WIDTH` bits: minuend, two's complement.
- `b` — input, `WIDTH` bits: subtrahend, two's complement.
- `out_valid` — output, 1 bit: result fields are valid.
- `out_ready` — input, 1 bit: the consumer accepts the result.
- `diff` — output, `WIDTH` bits: `a - b`, modulo 2^WIDTH.
- `borrow` — output, 1 bit: unsigned `a < b`, i.e. the inverse of the final carry.
- `ovf` — output, 1 bit: signed overflow, i.e. carry into the MSB XOR carry out of the MSB.
- `neg` — output, 1 bit: `diff[WIDTH-1]`.
- `mag` — output, `WIDTH` bits: magnitude of `diff`; see Configuration.

## Operation

- The operation is `a + ~b + 1`.
  - The carry flop is preset to 1 at operand capture.
  - Each RUN cycle adds `a_sh[0]`, `~b_sh[0]` and the carry.
  - The sum bit shifts into the MSB of the `diff` shift register, and both operand registers shift right.
- States:
  - IDLE: `in_ready`=1. On `in_valid && in_ready`, capture `a` and `b`, set the carry to 1, load the bit counter with `WIDTH-1`, and go to RUN.
  - RUN: one bit per cycle, with the counter decrementing.
    - On the last bit, record the MSB carry-in and carry-out, compute `borrow` and `ovf`, and register `neg`.
    - Next state is ABS if the macro is defined and the result is negative; otherwise DONE.
  - ABS: present only with the macro; see Configuration. Next state is DONE.
  - DONE: `out_valid`=1, and all result outputs hold stable. On `out_ready`, go to IDLE.
- `diff` is updated only as a shift register internally. The output `diff` is the register itself, so it is undefined-but-deterministic during RUN.
- Consumers sample result outputs only while `out_valid`=1.
- The inputs `a` and `b` are ignored outside the capture edge.
- No new operand is accepted in the cycle a result is accepted; `in_ready` rises the cycle after the DONE→IDLE transition.

## Timing

- Reset (asynchronous assert, synchronous release to IDLE) drives these values:
  - `in_ready`=1
  - `out_valid`=0
  - `diff`=0, `mag`=0
  - `borrow`=0, `ovf`=0, `neg`=0
  - All internal state cleared.
- Latency: operands are captured at edge k. The RUN bits occupy edges k+1 through k+WIDTH, and `out_valid` is high after edge k+WIDTH.
- With the macro and a negative result, ABS adds WIDTH edges.
- Throughput is one operation per WIDTH+2 cycles minimum, when `out_ready` is held at 1.
- Backpressure: DONE holds indefinitely while `out_ready`=0, and all outputs stay constant.
- Reset asserted mid-RUN or mid-ABS aborts the operation; no partial result is ever flagged valid.

## Configuration

- `SERIAL_SUB_ABS_EN` defined:
  - ABS state exists and performs a bit-serial two's complement of `diff` into `mag`: invert and add 1, LSB first, WIDTH cycles.
  - A non-negative `diff` is copied to `mag` at the end of RUN, with no extra cycles.
  - The most-negative value maps to `mag` = 1 followed by zeros (truncated 2^(WIDTH-1)).
  - `ovf` is unaffected.
- `SERIAL_SUB_ABS_EN` undefined:
  - The ABS state and its logic are absent.
  - `mag` is tied to 0.
  - Latency is always WIDTH.

## Test plan

- WIDTH=4, `a`=3, `b`=5 → `diff`=4'b1110, `borrow`=1, `ovf`=0, `neg`=1; `out_valid` 4 cycles after capture, or 8 cycles with the macro, where `mag`=4'b0010.
- `a`=4'b0111, `b`=4'b1000 → `diff`=4'b1111, `borrow`=1, `ovf`=1, `neg`=1.
- `a`=4'b1000, `b`=4'b0001 → `diff`=4'b0111, `borrow`=0, `ovf`=1, `neg`=0; `mag`=4'b0111 with no extra cycles.
- `a`=0, `b`=4'b1000 → `diff`=4'b1000, `ovf`=1, `neg`=1; with the macro, `mag`=4'b1000.
- Hold `out_ready`=0 for 5 cycles in DONE → outputs constant, `in_ready`=0, and `in_valid` is ignored; then pulse `out_ready` → `in_ready`=1 one cycle later.
- Pull `rst_n` low during the 2nd RUN cycle → all outputs go to reset values immediately; after release, `in_ready`=1 and the next operation (6-2 → `diff`=4'b0100) completes correctly.
